// File: rtl/rob_core_pkg.sv
// Shared ROB sizing, id type and entry layout for the reorder buffer.
// Id 0 means "no entry", so a W-bit tag addresses 2^W-1 real entries.
package rob_core_pkg;

   localparam int unsigned ROB_SIZE_WIDTH = 4;
   localparam int unsigned ROB_DEPTH      = (1 << ROB_SIZE_WIDTH) - 1;
   localparam int unsigned ROB_SLOTS      = 1 << ROB_SIZE_WIDTH;

   typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;

   typedef struct packed {
      logic        busy;
      logic        ready;
      logic [4:0]  rd;
      logic [31:0] value;
   } rob_entry_t;

   // Ids run 1..ROB_DEPTH and wrap back to 1, skipping 0.
   function automatic rob_id_t rob_id_next(input rob_id_t id);
      if (id == rob_id_t'(ROB_DEPTH)) begin
         return rob_id_t'(1);
      end
      return id + rob_id_t'(1);
   endfunction

endpackage

// File: rtl/rob_core.sv
// In-order reorder buffer: allocates ids at issue, captures CDB results, answers operand
// queries and retires one ready head entry per cycle.
module rob_core
   import rob_core_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      issue_valid,
   input  logic [4:0]                issue_in_rd,
   output logic                      rob_full,
   output logic [ROB_SIZE_WIDTH-1:0] alloc_rob_id,
   output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
   output logic [4:0]                issue_rd,
   input  logic                      wb_valid,
   input  logic [ROB_SIZE_WIDTH-1:0] wb_rob_id,
   input  logic [31:0]               wb_value,
   input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id1,
   input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id2,
   output logic [31:0]               get_value1,
   output logic [31:0]               get_value2,
   output logic                      get_ready1,
   output logic                      get_ready2,
   output logic                      commit_valid,
   output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
   output logic [4:0]                commit_rd,
   output logic [31:0]               commit_value,
   input  logic                      flush
);

   rob_entry_t entry_q [ROB_SLOTS];
   rob_entry_t entry_d [ROB_SLOTS];
   rob_id_t    head_q, head_d;
   rob_id_t    tail_q, tail_d;
   rob_id_t    count_q, count_d;
   logic       rob_full_q, rob_full_d;

   logic       issue_accept;
   rob_entry_t head_entry;

   assign head_entry   = entry_q[head_q];
   assign issue_accept = rdy && issue_valid && !rob_full_q && !flush;

   assign rob_full      = rob_full_q;
   assign alloc_rob_id  = tail_q;
   assign issue_rob_id  = (issue_accept && (issue_in_rd != 5'd0)) ? tail_q : '0;
   assign issue_rd      = issue_in_rd;

   // No bypass into commit: the head must already hold its result in storage.
   assign commit_valid  = rdy && !flush && (count_q != '0) && head_entry.busy &&
                          head_entry.ready;
   assign commit_rob_id = (commit_valid && (head_entry.rd != 5'd0)) ? head_q : '0;
   assign commit_rd     = head_entry.rd;
   assign commit_value  = head_entry.value;

   always_comb begin
      entry_d = entry_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rdy) begin
         if (flush) begin
            for (int i = 0; i < int'(ROB_SLOTS); i++) begin
               entry_d[i].busy  = 1'b0;
               entry_d[i].ready = 1'b0;
            end
            head_d  = rob_id_t'(1);
            tail_d  = rob_id_t'(1);
            count_d = '0;
         end else begin
            // Entry 0 is never busy, so a writeback tagged 0 falls out here.
            if (wb_valid && entry_q[wb_rob_id].busy) begin
               entry_d[wb_rob_id].value = wb_value;
               entry_d[wb_rob_id].ready = 1'b1;
            end
            if (commit_valid) begin
               entry_d[head_q].busy  = 1'b0;
               entry_d[head_q].ready = 1'b0;
               head_d                = rob_id_next(head_q);
            end
            if (issue_accept) begin
               entry_d[tail_q].busy  = 1'b1;
               entry_d[tail_q].ready = 1'b0;
               entry_d[tail_q].rd    = issue_in_rd;
               tail_d                = rob_id_next(tail_q);
            end
            unique case ({issue_accept, commit_valid})
               2'b10:   count_d = count_q + rob_id_t'(1);
               2'b01:   count_d = count_q - rob_id_t'(1);
               default: count_d = count_q;
            endcase
         end
      end
      rob_full_d = (count_d == rob_id_t'(ROB_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(ROB_SLOTS); i++) begin
            entry_q[i] <= '0;
         end
         head_q     <= rob_id_t'(1);
         tail_q     <= rob_id_t'(1);
         count_q    <= '0;
         rob_full_q <= 1'b0;
      end else begin
         entry_q    <= entry_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         rob_full_q <= rob_full_d;
      end
   end

   rob_id_t     ask_id    [2];
   logic [1:0]  get_ready_w;
   logic [31:0] get_value_w [2];

   assign ask_id[0] = ask_rob_id1;
   assign ask_id[1] = ask_rob_id2;

   for (genvar p = 0; p < 2; p++) begin : g_query
      logic bypass;
      assign bypass = wb_valid && (wb_rob_id == ask_id[p]);
      assign get_ready_w[p] = (ask_id[p] == '0) ? 1'b0 :
                              bypass            ? 1'b1 :
                              (entry_q[ask_id[p]].busy && entry_q[ask_id[p]].ready);
      assign get_value_w[p] = (ask_id[p] == '0) ? 32'd0    :
                              bypass            ? wb_value :
                              entry_q[ask_id[p]].value;
   end

   assign get_ready1 = get_ready_w[0];
   assign get_ready2 = get_ready_w[1];
   assign get_value1 = get_value_w[0];
   assign get_value2 = get_value_w[1];

endmodule

// File: tb/tb_rob_core.sv
// Directed bench for rob_core: a vector table of per-cycle inputs and expected outputs,
// plus hand sequences for fill/wrap, stall and flush.
module tb_rob_core;

   logic        clk = 1'b0;
   logic        rst, rdy, issue_valid, wb_valid, flush;
   logic [4:0]  issue_in_rd, issue_rd, commit_rd;
   logic [3:0]  alloc_rob_id, issue_rob_id, wb_rob_id, ask_rob_id1, ask_rob_id2;
   logic [3:0]  commit_rob_id;
   logic [31:0] wb_value, get_value1, get_value2, commit_value;
   logic        rob_full, get_ready1, get_ready2, commit_valid;

   int n_applied = 0;
   int n_miss    = 0;

   always #5 clk = ~clk;

   rob_core dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .issue_valid   (issue_valid),
      .issue_in_rd   (issue_in_rd),
      .rob_full      (rob_full),
      .alloc_rob_id  (alloc_rob_id),
      .issue_rob_id  (issue_rob_id),
      .issue_rd      (issue_rd),
      .wb_valid      (wb_valid),
      .wb_rob_id     (wb_rob_id),
      .wb_value      (wb_value),
      .ask_rob_id1   (ask_rob_id1),
      .ask_rob_id2   (ask_rob_id2),
      .get_value1    (get_value1),
      .get_value2    (get_value2),
      .get_ready1    (get_ready1),
      .get_ready2    (get_ready2),
      .commit_valid  (commit_valid),
      .commit_rob_id (commit_rob_id),
      .commit_rd     (commit_rd),
      .commit_value  (commit_value),
      .flush         (flush)
   );

   typedef struct {
      logic        rst, rdy, iv;
      logic [4:0]  ird;
      logic        wbv;
      logic [3:0]  wbid;
      logic [31:0] wbval;
      logic [3:0]  a1, a2;
      logic        fl;
      logic        full;
      logic [3:0]  alloc, irid;
      logic        cv;
      logic [3:0]  crid;
      logic [4:0]  crd;
      logic [31:0] cval;
      logic        gr1;
      logic [31:0] gv1;
      logic        gr2;
      logic [31:0] gv2;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input int rs, input int ry, input int iv, input int ird, input int wbv,
      input int wbid, input int wbval, input int a1, input int a2, input int fl,
      input int full, input int alloc, input int irid, input int cv, input int crid,
      input int crd, input int cval, input int gr1, input int gv1, input int gr2,
      input int gv2);
      vec_t v;
      v.rst = 1'(rs);   v.rdy = 1'(ry);     v.iv = 1'(iv);      v.ird = 5'(ird);
      v.wbv = 1'(wbv);  v.wbid = 4'(wbid);  v.wbval = 32'(wbval);
      v.a1 = 4'(a1);    v.a2 = 4'(a2);      v.fl = 1'(fl);
      v.full = 1'(full); v.alloc = 4'(alloc); v.irid = 4'(irid); v.cv = 1'(cv);
      v.crid = 4'(crid); v.crd = 5'(crd);    v.cval = 32'(cval);
      v.gr1 = 1'(gr1);  v.gv1 = 32'(gv1);   v.gr2 = 1'(gr2);    v.gv2 = 32'(gv2);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; rdy = 1'b1; issue_valid = 1'b0; issue_in_rd = 5'd0; wb_valid = 1'b0;
      wb_rob_id = 4'd0; wb_value = 32'd0; ask_rob_id1 = 4'd0; ask_rob_id2 = 4'd0;
      flush = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      idle();
   endtask

   task automatic apply(input vec_t v, input int idx);
      rst = v.rst; rdy = v.rdy; issue_valid = v.iv; issue_in_rd = v.ird;
      wb_valid = v.wbv; wb_rob_id = v.wbid; wb_value = v.wbval;
      ask_rob_id1 = v.a1; ask_rob_id2 = v.a2; flush = v.fl;
      #1;
      chk($sformatf("v%0d.rob_full", idx),      32'(rob_full),      32'(v.full));
      chk($sformatf("v%0d.alloc_rob_id", idx),  32'(alloc_rob_id),  32'(v.alloc));
      chk($sformatf("v%0d.issue_rob_id", idx),  32'(issue_rob_id),  32'(v.irid));
      chk($sformatf("v%0d.issue_rd", idx),      32'(issue_rd),      32'(v.ird));
      chk($sformatf("v%0d.commit_valid", idx),  32'(commit_valid),  32'(v.cv));
      chk($sformatf("v%0d.commit_rob_id", idx), 32'(commit_rob_id), 32'(v.crid));
      chk($sformatf("v%0d.commit_rd", idx),     32'(commit_rd),     32'(v.crd));
      chk($sformatf("v%0d.commit_value", idx),  commit_value,       v.cval);
      chk($sformatf("v%0d.get_ready1", idx),    32'(get_ready1),    32'(v.gr1));
      chk($sformatf("v%0d.get_value1", idx),    get_value1,         v.gv1);
      chk($sformatf("v%0d.get_ready2", idx),    32'(get_ready2),    32'(v.gr2));
      chk($sformatf("v%0d.get_value2", idx),    get_value2,         v.gv2);
      tick();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();

      //         rs ry iv rd wv wid wval       a1 a2 fl | fu al ir cv cid crd cval
      //         gr1 gv1 gr2 gv2
      // Reset state, single issue, rd=0 issue and its retire with commit_rob_id=0.
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 2, 0, 0, 0, 5, 0,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 5, 0,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 'h11, 1, 2, 0, 0, 3, 0, 0, 0, 5, 0,
                        1, 'h11, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 2, 'h22, 1, 2, 0, 0, 3, 0, 1, 1, 5, 'h11,
                        1, 'h11, 1, 'h22));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 0,   0, 3, 0, 1, 0, 0, 'h22,
                        0, 'h11, 1, 'h22));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0, 0,
                        0, 0, 0, 0));
      // Out-of-order writeback, in-order commit; id3 held until its result arrives.
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0, 0,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0,   0, 2, 2, 0, 0, 1, 0,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0,   0, 3, 3, 0, 0, 1, 0,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 2, 'hAA, 2, 0, 0, 0, 4, 0, 0, 0, 1, 0,
                        1, 'hAA, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 'h55, 2, 1, 0, 0, 4, 0, 0, 0, 1, 0,
                        1, 'hAA, 1, 'h55));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4, 0, 1, 1, 1, 'h55,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4, 0, 1, 2, 2, 'hAA,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 0, 0,   0, 4, 0, 0, 0, 3, 0,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 0, 0,   0, 4, 0, 0, 0, 3, 0,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 3, 'h33, 3, 0, 0, 0, 4, 0, 0, 0, 3, 0,
                        1, 'h33, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4, 0, 1, 3, 3, 'h33,
                        0, 0, 0, 0));
      // Writeback to a non-busy id and to id 0 is dropped; bypass still answers queries.
      vecs.push_back(mk(0, 1, 0, 0, 1, 9, 'hDEAD, 9, 0, 0, 0, 4, 0, 0, 0, 0, 0,
                        1, 'hDEAD, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 'h77, 9, 0, 0, 0, 4, 0, 0, 0, 0, 0,
                        0, 0, 0, 0));
      // Same-cycle query bypass, then the same answer from storage.
      vecs.push_back(mk(0, 1, 1, 7, 0, 0, 0, 0, 0, 0,   0, 4, 4, 0, 0, 0, 0,
                        0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 4, 'h1234, 4, 0, 0, 0, 5, 0, 0, 0, 7, 0,
                        1, 'h1234, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 0, 0,   0, 5, 0, 1, 4, 7, 'h1234,
                        1, 'h1234, 0, 0));

      foreach (vecs[i]) apply(vecs[i], i);

      // Fill to ROB_DEPTH, refuse when full even while the head commits, then wrap to id 1.
      do_reset();
      for (int i = 1; i <= 15; i++) begin
         issue_valid = 1'b1;
         issue_in_rd = 5'(i);
         #1;
         chk($sformatf("fill%0d.issue_rob_id", i), 32'(issue_rob_id), 32'(i));
         tick();
      end
      chk("fill.rob_full", 32'(rob_full), 32'd1);
      chk("fill.alloc_wrap", 32'(alloc_rob_id), 32'd1);
      issue_in_rd = 5'd1;
      #1;
      chk("full.issue_rob_id", 32'(issue_rob_id), 32'd0);
      tick();
      wb_valid = 1'b1; wb_rob_id = 4'd1; wb_value = 32'h99;
      #1;
      chk("full_wb.commit_valid", 32'(commit_valid), 32'd0);
      tick();
      wb_valid = 1'b0;
      #1;
      chk("full_commit.commit_valid", 32'(commit_valid), 32'd1);
      chk("full_commit.commit_value", commit_value, 32'h99);
      chk("full_commit.issue_rob_id", 32'(issue_rob_id), 32'd0);
      tick();
      issue_in_rd = 5'd4;
      #1;
      chk("after_commit.rob_full", 32'(rob_full), 32'd0);
      chk("after_commit.issue_rob_id", 32'(issue_rob_id), 32'd1);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("refill.rob_full", 32'(rob_full), 32'd1);
      chk("refill.alloc_rob_id", 32'(alloc_rob_id), 32'd2);

      // rdy=0 stall freezes head/tail/count and drops writebacks; then flush.
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         issue_valid = 1'b1;
         issue_in_rd = 5'(i);
         tick();
      end
      issue_valid = 1'b0;
      wb_valid = 1'b1; wb_rob_id = 4'd1; wb_value = 32'h5;
      tick();
      for (int i = 0; i < 3; i++) begin
         rdy = 1'b0; issue_valid = 1'b1; issue_in_rd = 5'd8;
         wb_valid = 1'b1; wb_rob_id = 4'd2; wb_value = 32'h42;
         #1;
         chk($sformatf("stall%0d.issue_rob_id", i), 32'(issue_rob_id), 32'd0);
         chk($sformatf("stall%0d.commit_valid", i), 32'(commit_valid), 32'd0);
         chk($sformatf("stall%0d.alloc_rob_id", i), 32'(alloc_rob_id), 32'd4);
         chk($sformatf("stall%0d.commit_rd", i),    32'(commit_rd),    32'd1);
         tick();
      end
      idle();
      ask_rob_id1 = 4'd2;
      #1;
      chk("unstall.commit_valid", 32'(commit_valid), 32'd1);
      chk("unstall.commit_rob_id", 32'(commit_rob_id), 32'd1);
      chk("unstall.commit_value", commit_value, 32'h5);
      chk("unstall.alloc_rob_id", 32'(alloc_rob_id), 32'd4);
      chk("unstall.wb_dropped", 32'(get_ready1), 32'd0);
      tick();
      issue_valid = 1'b1; issue_in_rd = 5'd4;
      #1;
      chk("pre_flush.issue_rob_id", 32'(issue_rob_id), 32'd4);
      tick();
      flush = 1'b1; issue_in_rd = 5'd9;
      wb_valid = 1'b1; wb_rob_id = 4'd2; wb_value = 32'h6;
      #1;
      chk("flush.issue_rob_id", 32'(issue_rob_id), 32'd0);
      chk("flush.commit_valid", 32'(commit_valid), 32'd0);
      tick();
      idle();
      #1;
      chk("post_flush.alloc_rob_id", 32'(alloc_rob_id), 32'd1);
      chk("post_flush.rob_full", 32'(rob_full), 32'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("post_flush%0d.commit_valid", i), 32'(commit_valid), 32'd0);
         tick();
      end
      issue_valid = 1'b1; issue_in_rd = 5'd10;
      #1;
      chk("post_flush.issue_rob_id", 32'(issue_rob_id), 32'd1);
      tick();
      idle();
      #1;
      chk("post_flush.new_not_ready", 32'(commit_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule
